// File: rtl/freq_meter_pkg.sv
// Shared types and default parameter values for the gated edge-counting frequency meter.
package freq_meter_pkg;

  typedef enum logic [1:0] {IDLE, GATE, HOLD} fm_state_t;

  localparam int unsigned DEF_GATE_CYCLES = 48_000_000;
  localparam int unsigned DEF_CNT_W       = 32;
  localparam int unsigned DEF_SYNC_STAGES = 2;
  localparam int unsigned DEF_EXP_COUNT   = 25_000;
  localparam int unsigned DEF_TOL         = 10;

  // Lower bound of the acceptance band, clamped at zero instead of wrapping.
  function automatic longint unsigned range_lo(input int unsigned exp_count,
                                               input int unsigned tol);
    return (exp_count > tol) ? longint'(exp_count - tol) : 64'd0;
  endfunction

  // Upper bound of the acceptance band, clamped to what a cnt_w+1 bit compare can hold.
  function automatic longint unsigned range_hi(input int unsigned exp_count,
                                               input int unsigned tol,
                                               input int unsigned cnt_w);
    longint unsigned hi_full;
    longint unsigned cmp_max;
    hi_full = longint'(exp_count) + longint'(tol);
    cmp_max = (64'd1 << (cnt_w + 1)) - 64'd1;
    return (hi_full > cmp_max) ? cmp_max : hi_full;
  endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// Multi-flop synchronizer for an asynchronous pin followed by a one-cycle rising-edge pulse.
module sync_edge_detect #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic sig_in,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], sig_in};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign rise = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/freq_meter.sv
// Gated edge-counting frequency meter with a valid/ready result port.
// Define FREQ_METER_RANGE_CHECK_EN to build the EXP_COUNT +/- TOL comparator behind freq_ok.
module freq_meter
  import freq_meter_pkg::*;
#(
  parameter int unsigned GATE_CYCLES = DEF_GATE_CYCLES,
  parameter int unsigned CNT_W       = DEF_CNT_W,
  parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int unsigned EXP_COUNT   = DEF_EXP_COUNT,
  parameter int unsigned TOL         = DEF_TOL
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sig_in,
  input  logic             enable,
  input  logic             meas_ready,
  output logic             meas_valid,
  output logic [CNT_W-1:0] meas_count,
  output logic             meas_ovf,
  output logic             freq_ok
);

  localparam int unsigned GATE_W = $clog2(GATE_CYCLES);
  localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);

  if (GATE_CYCLES < 2) begin : g_gate_chk
    $error("GATE_CYCLES must be at least 2");
  end
  if (SYNC_STAGES < 2) begin : g_sync_chk
    $error("SYNC_STAGES must be at least 2");
  end
  if (longint'(EXP_COUNT) + longint'(TOL) > 64'hFFFF_FFFF) begin : g_range_chk
    $error("EXP_COUNT + TOL exceeds 32 bits");
  end

  fm_state_t         state_q;
  logic [GATE_W-1:0] gate_cnt_q;
  logic [CNT_W-1:0]  edge_cnt_q;
  logic              ovf_q;
  logic              rise;
  logic [CNT_W-1:0]  edge_cnt_d;
  logic              ovf_d;
  logic              ok_d;

  sync_edge_detect #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk   (clk),
    .reset (reset),
    .sig_in(sig_in),
    .rise  (rise)
  );

  // Saturating edge counter: once all-ones, further edges only raise the overflow flag.
  always_comb begin
    edge_cnt_d = edge_cnt_q;
    ovf_d      = ovf_q;
    if (rise) begin
      if (&edge_cnt_q) begin
        ovf_d = 1'b1;
      end else begin
        edge_cnt_d = edge_cnt_q + 1'b1;
      end
    end
  end

`ifdef FREQ_METER_RANGE_CHECK_EN
  localparam logic [CNT_W:0] RANGE_LO = (CNT_W + 1)'(range_lo(EXP_COUNT, TOL));
  localparam logic [CNT_W:0] RANGE_HI = (CNT_W + 1)'(range_hi(EXP_COUNT, TOL, CNT_W));

  always_comb begin
    ok_d = ~ovf_d && ({1'b0, edge_cnt_d} >= RANGE_LO) && ({1'b0, edge_cnt_d} <= RANGE_HI);
  end
`else
  assign ok_d = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      gate_cnt_q <= '0;
      edge_cnt_q <= '0;
      ovf_q      <= 1'b0;
      meas_valid <= 1'b0;
      meas_count <= '0;
      meas_ovf   <= 1'b0;
      freq_ok    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (enable) begin
            state_q    <= GATE;
            gate_cnt_q <= '0;
            edge_cnt_q <= '0;
            ovf_q      <= 1'b0;
          end
        end
        GATE: begin
          if (!enable) begin
            state_q <= IDLE;
          end else begin
            gate_cnt_q <= gate_cnt_q + 1'b1;
            edge_cnt_q <= edge_cnt_d;
            ovf_q      <= ovf_d;
            // Last gate cycle: its own edge is already folded into edge_cnt_d.
            if (gate_cnt_q == GATE_LAST) begin
              meas_count <= edge_cnt_d;
              meas_ovf   <= ovf_d;
              freq_ok    <= ok_d;
              meas_valid <= 1'b1;
              state_q    <= HOLD;
            end
          end
        end
        HOLD: begin
          if (meas_ready) begin
            meas_valid <= 1'b0;
            if (enable) begin
              state_q    <= GATE;
              gate_cnt_q <= '0;
              edge_cnt_q <= '0;
              ovf_q      <= 1'b0;
            end else begin
              state_q <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
